stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

- Sequencing controller for the stopwatch datapath.
- Turns debounced button pulses into run, pause, lap and clear control.
- Generates the timebase tick and the per-digit `enable` chain for four cascaded BCD `Counter` digits (hundredths, tenths, seconds units, seconds tens; full count 59.99 s).
- Sits between the button debouncers and the digit counters, and drives the display path with a live or lap-frozen copy of the digits.

## Interface

Parameters:
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `TICK_HZ`, default 100: digit-0 increment rate.
  - `DIV = CLK_HZ/TICK_HZ`.
  - `CLK_HZ` must be an exact multiple of `TICK_HZ`, with `DIV ≥ 2`.
  - Prescaler width is `$clog2(DIV)`.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_stop` in 1: one-cycle debounced pulse.
- `lap_reset` in 1: one-cycle debounced pulse.
- `digits_in` in 16: current counter outputs.
  - [3:0] hundredths, [7:4] tenths, [11:8] seconds units, [15:12] seconds tens.
- `digit_en` out 4: `enable` for each digit counter, same bit order as `digits_in`.
- `cnt_clr` out 1: one-cycle clear pulse to the counters' active-high `rst`.
- `disp_out` out 16: digits to display.
- `state` out 2: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- `overflow` out 1: set when the count saturated (only with the macro in Configuration).

## Operation

FSM transitions:
- IDLE:
  - `start_stop` → RUN.
  - `lap_reset` → IDLE, pulse `cnt_clr`.
- RUN:
  - `start_stop` → PAUSE.
  - `lap_reset` → LAP.
- LAP:
  - `start_stop` → PAUSE; display becomes live again.
  - `lap_reset` → RUN.
- PAUSE:
  - `start_stop` → RUN.
  - `lap_reset` → IDLE; pulse `cnt_clr`, clear prescaler.
- Both pulses in the same cycle: `start_stop` wins, `lap_reset` is dropped.

Prescaler:
- Counts 0..DIV-1 and wraps, only in RUN or LAP.
- Holds its value in PAUSE, so the fractional tick is preserved across pause.
- Forced to 0 in IDLE.
- Registered `tick` is set for one cycle on the edge where the prescaler wraps from DIV-1 to 0.

Enable chain (combinational from `tick` and `digits_in`):
- `digit_en[0] = tick`.
- `digit_en[i] = digit_en[i-1] && (digits_in[i-1] == max[i-1])`.
- Maximum values: 9, 9, 9, 5.

Display:
- Outside LAP: `disp_out <= digits_in` every cycle.
- In LAP: `disp_out` holds its value. Counting continues underneath.

## Timing

- Reset values:
  - `state` = IDLE.
  - Prescaler = 0.
  - `tick` = 0.
  - `cnt_clr` = 0.
  - `disp_out` = 0.
  - `overflow` = 0.
- Reset is asynchronous and may assert mid-count; all registers return to the reset values immediately.
- State update: one cycle after the pulse is sampled.
- `cnt_clr`: registered. High for exactly one cycle, the cycle after the `lap_reset` pulse is sampled.
- First `digit_en[0]` after IDLE→RUN: high during the cycle following the DIV-th rising edge after the edge that sampled `start_stop`.
- Subsequent `digit_en[0]` pulses repeat every DIV cycles.
- A `tick` already registered when `start_stop` pauses is still honoured for that one cycle.
- `disp_out` lags `digits_in` by 1 cycle.
- LAP entry freezes the value registered on the entry edge.
- Wrap-around: at 59.99, a tick asserts all four `digit_en` bits and the counters roll to 00.00.

## Configuration

Macro: `STOPWATCH_OVERFLOW_STOP_EN`.
- Defined:
  - A tick arriving while `digits_in` = 0x5999 in RUN or LAP asserts no `digit_en` bit.
  - FSM → PAUSE; `overflow` ← 1, held until `cnt_clr`.
  - `start_stop` in PAUSE with `overflow` = 1 is ignored.
- Not defined:
  - The count wraps to 00.00 as described in Timing.
  - `overflow` is tied to 0.

## Test plan

All scenarios use `CLK_HZ`=1000 and `TICK_HZ`=100, so DIV=10.

1. Reset, then `start_stop` pulse → `state`=1; `digit_en[0]` pulses every 10 cycles, first one 10 edges after the sampling edge; `cnt_clr` stays 0.
2. `digits_in`=0x0199 at tick → `digit_en`=4'b0111. At 0x5999: `digit_en`=4'b1111 without the macro; with the macro, `digit_en`=0, `state`=2 and `overflow`=1.
3. RUN, `lap_reset` → `state`=3; `disp_out` frozen while `digits_in` advances. Second `lap_reset` → `state`=1; `disp_out` tracks 1 cycle later.
4. RUN, `start_stop` at prescaler=6, wait 50 cycles, `start_stop` → next tick 4 cycles after resume. PAUSE + `lap_reset` → `cnt_clr` high for 1 cycle, `state`=0.
5. `start_stop` and `lap_reset` in the same cycle from RUN → `state`=2, no LAP.
6. Assert `rst_n`=0 mid-RUN between edges → all outputs are at reset values before the next edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button sequencing, timebase prescaler and digit enable chain
// for a four-digit BCD stopwatch (hundredths .. seconds tens, full count 59.99 s).
// Optional feature: define STOPWATCH_OVERFLOW_STOP_EN to stop at 59.99 and flag
// overflow instead of wrapping to 00.00.
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        lap_reset,
  input  logic [15:0] digits_in,
  output logic [3:0]  digit_en,
  output logic        cnt_clr,
  output logic [15:0] disp_out,
  output logic [1:0]  state,
  output logic        overflow
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = $clog2(DIV);
  localparam logic [PW-1:0] PrescMax = PW'(DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StLap   = 2'd3
  } state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic          cnt_clr_q;
  logic [15:0]   disp_q;
  logic          ovf_hit;
  logic          ss_eff;

`ifdef STOPWATCH_OVERFLOW_STOP_EN
  logic ovf_q;
`endif

  // Tens digit only matters for the overflow compare; keeps lint quiet otherwise.
  logic unused_tens;
  assign unused_tens = ^digits_in[15:12];

  // Overflow detection and effective start/stop (ignored while stopped on overflow).
  always_comb begin
    ovf_hit = 1'b0;
    ss_eff  = start_stop;
`ifdef STOPWATCH_OVERFLOW_STOP_EN
    ovf_hit = tick_q && (digits_in == 16'h5999) && ((state_q == StRun) || (state_q == StLap));
    ss_eff  = start_stop && !((state_q == StPause) && ovf_q);
`endif
  end

  // Ripple enable chain: each digit advances when all lower digits are at their maximum.
  always_comb begin
    digit_en    = 4'b0000;
    digit_en[0] = tick_q;
    digit_en[1] = digit_en[0] && (digits_in[3:0] == 4'd9);
    digit_en[2] = digit_en[1] && (digits_in[7:4] == 4'd9);
    digit_en[3] = digit_en[2] && (digits_in[11:8] == 4'd9);
    if (ovf_hit) begin
      digit_en = 4'b0000;
    end
  end

  // FSM, prescaler, tick, clear pulse and display latch, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      cnt_clr_q <= 1'b0;
      disp_q    <= 16'h0000;
`ifdef STOPWATCH_OVERFLOW_STOP_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      cnt_clr_q <= 1'b0;
      tick_q    <= 1'b0;

      // Prescaler runs in RUN/LAP, holds in PAUSE so a partial tick survives a pause.
      unique case (state_q)
        StRun, StLap: begin
          if (presc_q == PrescMax) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        StPause: presc_q <= presc_q;
        StIdle:  presc_q <= '0;
      endcase

      if (state_q != StLap) begin
        disp_q <= digits_in;
      end

      if (ovf_hit) begin
        state_q <= StPause;
`ifdef STOPWATCH_OVERFLOW_STOP_EN
        ovf_q   <= 1'b1;
`endif
      end else if (ss_eff) begin
        // start_stop wins over a simultaneous lap_reset.
        unique case (state_q)
          StIdle:  state_q <= StRun;
          StRun:   state_q <= StPause;
          StLap:   state_q <= StPause;
          StPause: state_q <= StRun;
        endcase
      end else if (lap_reset) begin
        unique case (state_q)
          StIdle: begin
            cnt_clr_q <= 1'b1;
`ifdef STOPWATCH_OVERFLOW_STOP_EN
            ovf_q     <= 1'b0;
`endif
          end
          StRun:   state_q <= StLap;
          StLap:   state_q <= StRun;
          StPause: begin
            state_q   <= StIdle;
            cnt_clr_q <= 1'b1;
            presc_q   <= '0;
`ifdef STOPWATCH_OVERFLOW_STOP_EN
            ovf_q     <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

  assign state    = state_q;
  assign cnt_clr  = cnt_clr_q;
  assign disp_out = disp_q;
`ifdef STOPWATCH_OVERFLOW_STOP_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV = 10. Expected digit_en pulses are queued with
// the cycle they must appear in; a monitor pops and compares on every nonzero pulse.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap_reset = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  digit_en;
  logic        cnt_clr;
  logic [15:0] disp_out;
  logic [1:0]  state;
  logic        overflow;

  typedef struct {
    int         cyc;
    logic [3:0] en;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  stopwatch_ctrl #(
    .CLK_HZ (1000),
    .TICK_HZ(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_stop(start_stop),
    .lap_reset (lap_reset),
    .digits_in (digits_in),
    .digit_en  (digit_en),
    .cnt_clr   (cnt_clr),
    .disp_out  (disp_out),
    .state     (state),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every enable pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_tick: no enable pulse, required en=%b at cycle %0d",
                 exp_q[0].en, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (digit_en != 4'b0000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick: en=%b at cycle %0d, required none", digit_en, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.en != digit_en) begin
            errors++;
            $display("FAIL tick: en=%b at cycle %0d, required en=%b at cycle %0d",
                     digit_en, cyc, e.en, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] en);
    exp_t e;
    e.cyc = c;
    e.en  = en;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse tasks return the number of the edge that sampled the pulse.
  task automatic pulse_ss(output int s);
    start_stop = 1'b1;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    s = cyc;
  endtask

  task automatic pulse_lr(output int s);
    lap_reset = 1'b1;
    @(posedge clk);
    #1;
    lap_reset = 1'b0;
    s = cyc;
  endtask

  task automatic pulse_both(output int s);
    start_stop = 1'b1;
    lap_reset  = 1'b1;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    lap_reset  = 1'b0;
    s = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int x;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_disp", 32'(disp_out), 32'h0);
    chk("rst_cnt_clr", 32'(cnt_clr), 32'd0);
    chk("rst_digit_en", 32'(digit_en), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: start, ticks every 10 cycles, first 10 edges after the sampling edge
    pulse_ss(t);
    chk("s1_state_run", 32'(state), 32'd1);
    push(t + 10, 4'b0001);
    push(t + 20, 4'b0001);
    push(t + 30, 4'b0001);
    wait_until(t + 31);
    chk("s1_cnt_clr_low", 32'(cnt_clr), 32'd0);

    // 2: carry chain and full-count behaviour
    wait_until(t + 35);
    digits_in = 16'h0199;
    push(t + 40, 4'b0111);
    wait_until(t + 45);
    digits_in = 16'h5999;
`ifndef STOPWATCH_OVERFLOW_STOP_EN
    push(t + 50, 4'b1111);
`endif
    wait_until(t + 52);
    chk("s2_disp_lag", 32'(disp_out), 32'h5999);
`ifdef STOPWATCH_OVERFLOW_STOP_EN
    chk("s2_ovf_state", 32'(state), 32'd2);
    chk("s2_ovf_flag", 32'(overflow), 32'd1);
    pulse_ss(x);
    chk("s2_ss_ignored", 32'(state), 32'd2);
`else
    chk("s2_still_run", 32'(state), 32'd1);
    pulse_ss(x);
    chk("s2_pause", 32'(state), 32'd2);
`endif
    pulse_lr(x);
    chk("s2_cnt_clr_hi", 32'(cnt_clr), 32'd1);
    chk("s2_idle", 32'(state), 32'd0);
    chk("s2_ovf_cleared", 32'(overflow), 32'd0);
    digits_in = 16'h0000;
    @(posedge clk);
    #1;
    chk("s2_cnt_clr_lo", 32'(cnt_clr), 32'd0);

    // 3: lap freeze and release
    pulse_ss(t);
    wait_until(t + 2);
    digits_in = 16'h0012;
    wait_until(t + 4);
    pulse_lr(x);
    chk("s3_lap", 32'(state), 32'd3);
    wait_until(t + 6);
    digits_in = 16'h0345;
    push(t + 10, 4'b0001);
    wait_until(t + 8);
    chk("s3_frozen_a", 32'(disp_out), 32'h0012);
    wait_until(t + 12);
    chk("s3_frozen_b", 32'(disp_out), 32'h0012);
    pulse_lr(x);
    chk("s3_back_run", 32'(state), 32'd1);
    chk("s3_still_frozen", 32'(disp_out), 32'h0012);
    @(posedge clk);
    #1;
    chk("s3_live", 32'(disp_out), 32'h0345);

    // 4: pause with prescaler held at 6, resume gives tick 4 edges later
    push(t + 20, 4'b0001);
    wait_until(t + 25);
    pulse_ss(x);
    chk("s4_pause", 32'(state), 32'd2);
    wait_until(t + 75);
    pulse_ss(x);
    chk("s4_resume", 32'(state), 32'd1);
    push(t + 80, 4'b0001);
    wait_until(t + 82);
    pulse_ss(x);
    pulse_lr(x);
    chk("s4_cnt_clr_hi", 32'(cnt_clr), 32'd1);
    chk("s4_idle", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    chk("s4_cnt_clr_lo", 32'(cnt_clr), 32'd0);
    digits_in = 16'h0000;

    // 5: simultaneous pulses from RUN, start_stop wins
    pulse_ss(t);
    wait_until(t + 3);
    pulse_both(x);
    chk("s5_pause", 32'(state), 32'd2);
    repeat (2) @(posedge clk);
    #1;
    chk("s5_no_lap", 32'(state), 32'd2);
    pulse_lr(x);
    chk("s5_idle", 32'(state), 32'd0);

    // 6: asynchronous reset mid-run
    pulse_ss(t);
    digits_in = 16'h0042;
    push(t + 10, 4'b0001);
    wait_until(t + 15);
    chk("s6_disp", 32'(disp_out), 32'h0042);
    chk("s6_run", 32'(state), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_state", 32'(state), 32'd0);
    chk("s6_rst_disp", 32'(disp_out), 32'h0);
    chk("s6_rst_cnt_clr", 32'(cnt_clr), 32'd0);
    chk("s6_rst_digit_en", 32'(digit_en), 32'd0);
    chk("s6_rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    digits_in = 16'h0000;
    pulse_ss(t);
    push(t + 10, 4'b0001);
    wait_until(t + 12);
    chk("s6_restart_run", 32'(state), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
